// File: rtl/pipeline_riscv_pkg.sv
// Shared opcodes, instruction classes and pipeline register layouts for pipeline_riscv.
// PIPELINE_RISCV_MUL_EN selects whether opcode 05 (MUL) decodes as a register-register op.
package pipeline_riscv_pkg;

    localparam int MEM_WORDS_DEF = 1024;
    localparam int XLEN          = 32;
    localparam int OP_W          = 6;
    localparam int REG_W         = 5;
    localparam int IMM_W         = 16;

    localparam logic [OP_W-1:0] OP_ADD   = 6'h00;
    localparam logic [OP_W-1:0] OP_SUB   = 6'h01;
    localparam logic [OP_W-1:0] OP_AND   = 6'h02;
    localparam logic [OP_W-1:0] OP_OR    = 6'h03;
    localparam logic [OP_W-1:0] OP_SLT   = 6'h04;
    localparam logic [OP_W-1:0] OP_MUL   = 6'h05;
    localparam logic [OP_W-1:0] OP_LW    = 6'h08;
    localparam logic [OP_W-1:0] OP_SW    = 6'h09;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_SUBI  = 6'h0B;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_BNEQZ = 6'h0D;
    localparam logic [OP_W-1:0] OP_BEQZ  = 6'h0E;
    localparam logic [OP_W-1:0] OP_NOP   = 6'h3E;
    localparam logic [OP_W-1:0] OP_HLT   = 6'h3F;

    localparam logic [XLEN-1:0] NOP_WORD = {OP_NOP, 26'd0};

    // NOP is encoded as zero so an all-zero pipeline register is a bubble
    typedef enum logic [2:0] {
        NOP    = 3'd0,
        RR_ALU = 3'd1,
        RM_ALU = 3'd2,
        LOAD   = 3'd3,
        STORE  = 3'd4,
        BRANCH = 3'd5,
        HALT   = 3'd6
    } iclass_t;

`ifdef PIPELINE_RISCV_MUL_EN
    localparam iclass_t MUL_CLASS = RR_ALU;
`else
    localparam iclass_t MUL_CLASS = NOP;
`endif

    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] npc;
    } if_id_t;

    typedef struct packed {
        iclass_t         cls;
        logic [OP_W-1:0] op;
        logic [REG_W-1:0] dest;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] npc;
    } id_ex_t;

    typedef struct packed {
        iclass_t          cls;
        logic [REG_W-1:0] dest;
        logic [XLEN-1:0]  alu_out;
        logic [XLEN-1:0]  b;
    } ex_mem_t;

    typedef struct packed {
        iclass_t          cls;
        logic [REG_W-1:0] dest;
        logic [XLEN-1:0]  result;
    } mem_wb_t;

    function automatic iclass_t classify(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: classify = RR_ALU;
            OP_MUL:                                classify = MUL_CLASS;
            OP_ADDI, OP_SUBI, OP_SLTI:             classify = RM_ALU;
            OP_LW:                                 classify = LOAD;
            OP_SW:                                 classify = STORE;
            OP_BNEQZ, OP_BEQZ:                     classify = BRANCH;
            OP_HLT:                                classify = HALT;
            default:                               classify = NOP;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_riscv_if.sv
// Status bus of the pipeline_riscv core: the halted flag seen by the environment.
interface pipeline_riscv_if;
    logic halted;

    modport master (output halted);
    modport slave  (input  halted);
endinterface

// File: rtl/pipeline_riscv_alu.sv
// Combinational ALU for pipeline_riscv; also forms load/store addresses.
// The multiplier exists only when PIPELINE_RISCV_MUL_EN is defined.
module pipeline_riscv_alu
    import pipeline_riscv_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: y = a + b;
            OP_SUB, OP_SUBI:               y = a - b;
            OP_AND:                        y = a & b;
            OP_OR:                         y = a | b;
            OP_SLT, OP_SLTI:               y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef PIPELINE_RISCV_MUL_EN
            OP_MUL:                        y = a * b;
`endif
            default:                       y = '0;
        endcase
    end

endmodule

// File: rtl/pipeline_riscv.sv
// Five-stage in-order pipeline (IF/ID/EX/MEM/WB) over a unified word memory, no forwarding.
// Define PIPELINE_RISCV_MUL_EN to implement MUL (opcode 05); otherwise it is a NOP.
module pipeline_riscv
    import pipeline_riscv_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_riscv_if.master bus
);

    localparam int     AW           = $clog2(MEM_WORDS);
    localparam if_id_t IF_ID_BUBBLE = '{ir: NOP_WORD, npc: '0};

    logic [XLEN-1:0] RegFile [0:31];
    logic [XLEN-1:0] Memory  [0:MEM_WORDS-1];
    logic [XLEN-1:0] PC;
    logic            HALTED;
    logic            TAKEN_BRANCH;

    if_id_t  if_id;
    id_ex_t  id_ex;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;

    logic [OP_W-1:0]  id_op;
    logic [REG_W-1:0] id_rs, id_rt, id_rd, id_dest;
    logic [XLEN-1:0]  id_imm, id_a, id_b;
    iclass_t          id_cls;

    logic [XLEN-1:0]  alu_b, alu_y, br_target;
    logic             br_take, redirect;

    logic [XLEN-1:0]  mem_rdata;
    logic             mem_we, wb_we, wb_halt;

    assign bus.halted = HALTED;

    assign id_op   = if_id.ir[31:26];
    assign id_rs   = if_id.ir[25:21];
    assign id_rt   = if_id.ir[20:16];
    assign id_rd   = if_id.ir[15:11];
    assign id_imm  = {{(XLEN-IMM_W){if_id.ir[IMM_W-1]}}, if_id.ir[IMM_W-1:0]};
    assign id_cls  = classify(id_op);
    assign id_dest = (id_cls == RR_ALU) ? id_rd : id_rt;

    // Write-first register file: a same-cycle WB write is visible to the ID read
    always_comb begin
        id_a = RegFile[id_rs];
        id_b = RegFile[id_rt];
        if (wb_we && mem_wb.dest == id_rs) id_a = mem_wb.result;
        if (wb_we && mem_wb.dest == id_rt) id_b = mem_wb.result;
    end

    assign alu_b     = (id_ex.cls == RR_ALU) ? id_ex.b : id_ex.imm;
    assign br_target = id_ex.npc + id_ex.imm;
    assign br_take   = (id_ex.cls == BRANCH) &&
                       (((id_ex.op == OP_BNEQZ) && (id_ex.a != '0)) ||
                        ((id_ex.op == OP_BEQZ)  && (id_ex.a == '0)));

    pipeline_riscv_alu u_alu (
        .op (id_ex.op),
        .a  (id_ex.a),
        .b  (alu_b),
        .y  (alu_y)
    );

    // HLT in WB fences everything younger: no redirect, no store from MEM
    assign wb_halt   = (mem_wb.cls == HALT);
    assign redirect  = br_take && !wb_halt;
    assign mem_rdata = Memory[ex_mem.alu_out[AW-1:0]];
    assign mem_we    = (ex_mem.cls == STORE) && !wb_halt && !HALTED;
    assign wb_we     = ((mem_wb.cls == RR_ALU) || (mem_wb.cls == RM_ALU) || (mem_wb.cls == LOAD)) &&
                       (mem_wb.dest != '0) && !HALTED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            if_id        <= IF_ID_BUBBLE;
            id_ex        <= '0;
            ex_mem       <= '0;
            mem_wb       <= '0;
        end else if (!HALTED) begin
            HALTED       <= wb_halt;
            TAKEN_BRANCH <= redirect;
            PC           <= redirect ? br_target : PC + 32'd1;
            if (redirect) begin
                if_id <= IF_ID_BUBBLE;
                id_ex <= '0;
            end else begin
                if_id <= '{ir: Memory[PC[AW-1:0]], npc: PC + 32'd1};
                id_ex <= '{cls: id_cls, op: id_op, dest: id_dest, a: id_a, b: id_b,
                           imm: id_imm, npc: if_id.npc};
            end
            ex_mem <= '{cls: id_ex.cls, dest: id_ex.dest, alu_out: alu_y, b: id_ex.b};
            mem_wb <= '{cls: ex_mem.cls, dest: ex_mem.dest,
                        result: (ex_mem.cls == LOAD) ? mem_rdata : ex_mem.alu_out};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) RegFile[i] <= '0;
        end else if (wb_we) begin
            RegFile[mem_wb.dest] <= mem_wb.result;
        end
    end

    // Memory contents survive reset; the environment preloads program and data
    always_ff @(posedge clk) begin
        if (mem_we) Memory[ex_mem.alu_out[AW-1:0]] <= ex_mem.b;
    end

endmodule

// File: tb/tb_pipeline_riscv.sv
// Self-checking bench for pipeline_riscv: directed programs plus random straight-line
// programs, each compared against an instruction-level interpreter of the ISA.
module tb_pipeline_riscv;
    import pipeline_riscv_pkg::*;

    localparam logic [31:0] NOP_W = 32'hF800_0000;
    localparam logic [31:0] HLT_W = 32'hFC00_0000;
`ifdef PIPELINE_RISCV_MUL_EN
    localparam logic [31:0] LOOP_R2 = 32'd120;
`else
    localparam logic [31:0] LOOP_R2 = 32'd1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pipeline_riscv_if bus ();

    pipeline_riscv #(.MEM_WORDS(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] prog   [$];
    int          d_addr [$];
    logic [31:0] d_val  [$];
    logic [31:0] m_mem  [0:1023];
    logic [31:0] m_reg  [0:31];
    int          m_taken;
    int          m_hpc;
    logic [5:0]  rnd_ops [0:10];
    logic [5:0]  r_op;
    logic [31:0] r_w;
    logic [31:0] fence_val;
    int          ra, rb, rc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic set_reg(input int r, input logic [31:0] v);
        if (r != 0) m_reg[r] = v;
    endtask

    // Sequential ISA interpreter: one instruction at a time, branches redirect immediately
    task automatic model_run();
        int          pc, rs, rt, rd;
        logic [31:0] ir, a, b, imm;
        logic [9:0]  ea;
        logic [5:0]  op;
        bit          done;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_taken = 0;
        m_hpc   = -1;
        pc      = 0;
        done    = 1'b0;
        for (int step = 0; step < 20000 && !done; step++) begin
            ir  = m_mem[pc & 1023];
            op  = ir[31:26];
            rs  = int'(ir[25:21]);
            rt  = int'(ir[20:16]);
            rd  = int'(ir[15:11]);
            a   = m_reg[rs];
            b   = m_reg[rt];
            imm = {{16{ir[15]}}, ir[15:0]};
            ea  = 10'(a + imm);
            pc  = pc + 1;
            case (op)
                6'h00: set_reg(rd, a + b);
                6'h01: set_reg(rd, a - b);
                6'h02: set_reg(rd, a & b);
                6'h03: set_reg(rd, a | b);
                6'h04: set_reg(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                6'h05: begin
`ifdef PIPELINE_RISCV_MUL_EN
                    set_reg(rd, a * b);
`endif
                end
                6'h0A: set_reg(rt, a + imm);
                6'h0B: set_reg(rt, a - imm);
                6'h0C: set_reg(rt, ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0);
                6'h08: set_reg(rt, m_mem[ea]);
                6'h09: m_mem[ea] = b;
                6'h0D, 6'h0E: begin
                    if ((op == 6'h0D && a != 0) || (op == 6'h0E && a == 0)) begin
                        pc = pc + int'(imm);
                        m_taken++;
                    end
                end
                6'h3F: begin
                    done  = 1'b1;
                    m_hpc = pc - 1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic run_test(input string name, input int reset_at);
        logic [31:0] w, orr;
        int          cycles, taken, dbl, diffs;
        bit          prev, did_rst;
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) begin
            if (i < prog.size())           w = prog[i];
            else if (i >= 512 && i < 544)  w = $urandom;
            else                           w = NOP_W;
            m_mem[i]        = w;
            dut.Memory[i]   = w;
        end
        foreach (d_addr[k]) begin
            m_mem[d_addr[k]]      = d_val[k];
            dut.Memory[d_addr[k]] = d_val[k];
        end
        model_run();
        check_val({name, "_reset_pc"}, dut.PC, 32'd0);
        check_val({name, "_reset_halted"}, 32'(bus.halted), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        cycles  = 0;
        taken   = 0;
        dbl     = 0;
        prev    = 1'b0;
        did_rst = 1'b0;
        while (bus.halted !== 1'b1 && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            if (dut.TAKEN_BRANCH) begin
                taken++;
                if (prev) dbl++;
            end
            prev = dut.TAKEN_BRANCH;
            if (!did_rst && cycles == reset_at) begin
                rst_n = 1'b0;
                #1;
                orr = '0;
                for (int i = 0; i < 32; i++) orr = orr | dut.RegFile[i];
                check_val({name, "_midrst_pc"}, dut.PC, 32'd0);
                check_val({name, "_midrst_halted"}, 32'(bus.halted), 32'd0);
                check_val({name, "_midrst_taken"}, 32'(dut.TAKEN_BRANCH), 32'd0);
                check_val({name, "_midrst_regs"}, orr, 32'd0);
                @(negedge clk);
                rst_n   = 1'b1;
                cycles  = 0;
                taken   = 0;
                dbl     = 0;
                prev    = 1'b0;
                did_rst = 1'b1;
            end
        end
        check_val({name, "_halted"}, 32'(bus.halted), 32'd1);
        repeat (8) begin
            @(negedge clk);
            if (dut.TAKEN_BRANCH) taken++;
        end
        check_val({name, "_halt_hold"}, 32'(bus.halted), 32'd1);
        check_val({name, "_pc_frozen"}, dut.PC, 32'(m_hpc + 5));
        check_val({name, "_taken_cnt"}, 32'(taken), 32'(m_taken));
        check_val({name, "_taken_pulse"}, 32'(dbl), 32'd0);
        for (int i = 0; i < 32; i++)
            check_val($sformatf("%s_r%0d", name, i), dut.RegFile[i], m_reg[i]);
        diffs = 0;
        for (int i = 0; i < 1024; i++)
            if (dut.Memory[i] !== m_mem[i]) diffs++;
        check_val({name, "_mem_diff"}, 32'(diffs), 32'd0);
    endtask

    initial begin
        rnd_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL,
                    OP_ADDI, OP_SUBI, OP_SLTI, OP_LW, OP_SW};
        rst_n = 1'b0;

        prog = '{32'h2801000A, 32'h28020014, NOP_W, NOP_W, 32'h00222000, HLT_W};
        d_addr.delete(); d_val.delete();
        run_test("imm_add", -1);
        check_val("imm_add_r4_const", dut.RegFile[4], 32'd30);
        check_val("imm_add_pc_const", dut.PC, 32'd10);

        prog = '{enc_i(OP_LW, 2, 0, 16'd120), NOP_W, NOP_W, enc_i(OP_ADDI, 2, 2, 16'd45),
                 NOP_W, NOP_W, enc_i(OP_SW, 2, 0, 16'd121), HLT_W};
        d_addr = '{120}; d_val = '{32'd85};
        run_test("ldst", -1);
        check_val("ldst_mem121_const", dut.Memory[121], 32'd130);
        check_val("ldst_r2_const", dut.RegFile[2], 32'd130);

        prog = '{enc_i(OP_ADDI, 1, 0, 16'd5), enc_i(OP_ADDI, 2, 0, 16'd1), NOP_W, NOP_W,
                 enc_r(OP_MUL, 2, 2, 1), enc_i(OP_SUBI, 1, 1, 16'd1), NOP_W, NOP_W,
                 enc_i(OP_BNEQZ, 0, 1, 16'hFFFB), HLT_W};
        d_addr.delete(); d_val.delete();
        run_test("loop", -1);
        check_val("loop_r2_const", dut.RegFile[2], LOOP_R2);
        check_val("loop_r1_const", dut.RegFile[1], 32'd0);
        run_test("loop_rst", 15);
        check_val("loop_rst_r2_const", dut.RegFile[2], LOOP_R2);

        prog = '{enc_i(OP_ADDI, 1, 0, 16'd3), NOP_W, NOP_W, enc_i(OP_BEQZ, 0, 0, 16'd2),
                 enc_i(OP_ADDI, 5, 0, 16'd9), enc_i(OP_ADDI, 5, 0, 16'd9),
                 enc_i(OP_ADDI, 6, 0, 16'd11), HLT_W};
        run_test("squash", -1);
        check_val("squash_r5_const", dut.RegFile[5], 32'd0);
        check_val("squash_r6_const", dut.RegFile[6], 32'd11);

        fence_val = $urandom;
        prog = '{enc_i(OP_ADDI, 1, 0, 16'd9), NOP_W, NOP_W, HLT_W,
                 enc_i(OP_SW, 1, 0, 16'd700), enc_i(OP_ADDI, 3, 0, 16'd7)};
        d_addr = '{700}; d_val = '{fence_val};
        run_test("fence", -1);
        check_val("fence_r3_const", dut.RegFile[3], 32'd0);
        check_val("fence_mem700", dut.Memory[700], fence_val);

        for (int p = 0; p < 3; p++) begin
            prog.delete(); d_addr.delete(); d_val.delete();
            for (int r = 1; r < 8; r++) prog.push_back(enc_i(OP_ADDI, r, 0, 16'($urandom)));
            prog.push_back(NOP_W);
            prog.push_back(NOP_W);
            for (int k = 0; k < 14; k++) begin
                r_op = rnd_ops[$urandom_range(0, 10)];
                ra   = $urandom_range(0, 7);
                rb   = $urandom_range(0, 7);
                rc   = $urandom_range(0, 7);
                if (r_op == OP_LW || r_op == OP_SW)
                    r_w = enc_i(r_op, ra, 0, 16'(512 + $urandom_range(0, 31)));
                else if (r_op == OP_ADDI || r_op == OP_SUBI || r_op == OP_SLTI)
                    r_w = enc_i(r_op, ra, rb, 16'($urandom));
                else
                    r_w = enc_r(r_op, ra, rb, rc);
                prog.push_back(r_w);
                prog.push_back(NOP_W);
                prog.push_back(NOP_W);
            end
            prog.push_back(HLT_W);
            run_test($sformatf("rnd%0d", p), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
